// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive side of the 4-wire LCD SPI link. Rebuilds {dc,byte}
// words from CS/DC/SCLK/MOSI and decodes the CASET/RASET/RAMWR/SWRESET subset
// into RGB565 pixel writes with x/y coordinates.
`timescale 1ns/1ps
module lcd_spi_rx #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320
) (
    input  logic        sys_clk_50MHz,
    input  logic        sys_rst_n,
    input  logic        spi_cs,
    input  logic        spi_dc,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    output logic        byte_valid,
    output logic [8:0]  byte_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        pixel_valid,
    output logic [15:0] pixel_data,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        frame_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CASET = 2'd1;
    localparam logic [1:0] ST_RASET = 2'd2;
    localparam logic [1:0] ST_RAMWR = 2'd3;

    localparam logic [8:0] XE_RST = 9'(WIDTH - 1);
    localparam logic [8:0] YE_RST = 9'(HEIGHT - 1);

    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic dc_meta_q, dc_sync_q;
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic sclk_rise, cs_rise;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic       byte_valid_q, byte_valid_d;
    logic [8:0] byte_data_q, byte_data_d;
    logic       frame_err_q, frame_err_d;

    logic [1:0]  state_q, state_d;
    logic [1:0]  param_cnt_q, param_cnt_d;
    logic        sh_start_hi_q, sh_start_hi_d;
    logic [7:0]  sh_start_lo_q, sh_start_lo_d;
    logic        sh_end_hi_q, sh_end_hi_d;
    logic [8:0]  xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [8:0]  x_q, x_d, y_q, y_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [7:0]  cmd_code_q, cmd_code_d;
    logic        pixel_valid_q, pixel_valid_d;
    logic [15:0] pixel_data_q, pixel_data_d;
    logic [8:0]  pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;

    // Two-flop synchronizers for all SPI pins; a third flop on CS and SCLK gives edge detection
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            dc_meta_q   <= 1'b0;
            dc_sync_q   <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            cs_meta_q   <= spi_cs;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            dc_meta_q   <= spi_dc;
            dc_sync_q   <= dc_meta_q;
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;

    // Bit assembly: shift MSB first on each SCLK rise while selected; CS high drops a partial byte
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        byte_data_d  = byte_data_q;
        frame_err_d  = 1'b0;
        if (cs_sync_q) begin
            bit_cnt_d   = 3'd0;
            frame_err_d = cs_rise && (bit_cnt_q != 3'd0);
        end else if (sclk_rise) begin
            shift_d = {shift_q[5:0], mosi_sync_q};
            if (bit_cnt_q == 3'd7) begin
                bit_cnt_d    = 3'd0;
                byte_valid_d = 1'b1;
                byte_data_d  = {dc_sync_q, shift_q, mosi_sync_q};
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    // Command decoder: commands always abort; parameters fill the window; RAMWR pairs bytes into pixels
    always_comb begin
        state_d       = state_q;
        param_cnt_d   = param_cnt_q;
        sh_start_hi_d = sh_start_hi_q;
        sh_start_lo_d = sh_start_lo_q;
        sh_end_hi_d   = sh_end_hi_q;
        xs_d          = xs_q;
        xe_d          = xe_q;
        ys_d          = ys_q;
        ye_d          = ye_q;
        x_d           = x_q;
        y_d           = y_q;
        phase_d       = phase_q;
        hi_d          = hi_q;
        cmd_valid_d   = 1'b0;
        cmd_code_d    = cmd_code_q;
        pixel_valid_d = 1'b0;
        pixel_data_d  = pixel_data_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        if (cs_sync_q) begin
            phase_d = 1'b0;
        end
        if (byte_valid_q) begin
            if (!byte_data_q[8]) begin
                cmd_valid_d = 1'b1;
                cmd_code_d  = byte_data_q[7:0];
                param_cnt_d = 2'd0;
                phase_d     = 1'b0;
                case (byte_data_q[7:0])
                    8'h2A: state_d = ST_CASET;
                    8'h2B: state_d = ST_RASET;
                    8'h2C: begin
                        state_d = ST_RAMWR;
                        x_d     = xs_q;
                        y_d     = ys_q;
                    end
                    8'h01: begin
                        state_d = ST_IDLE;
                        xs_d    = 9'd0;
                        xe_d    = XE_RST;
                        ys_d    = 9'd0;
                        ye_d    = YE_RST;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end else begin
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        param_cnt_d = param_cnt_q + 2'd1;
                        case (param_cnt_q)
                            2'd0: sh_start_hi_d = byte_data_q[0];
                            2'd1: sh_start_lo_d = byte_data_q[7:0];
                            2'd2: sh_end_hi_d   = byte_data_q[0];
                            default: begin
                                state_d = ST_IDLE;
                                if (state_q == ST_CASET) begin
                                    xs_d = {sh_start_hi_q, sh_start_lo_q};
                                    xe_d = {sh_end_hi_q, byte_data_q[7:0]};
                                end else begin
                                    ys_d = {sh_start_hi_q, sh_start_lo_q};
                                    ye_d = {sh_end_hi_q, byte_data_q[7:0]};
                                end
                            end
                        endcase
                    end
                    ST_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = byte_data_q[7:0];
                            phase_d = 1'b1;
                        end else begin
                            phase_d       = 1'b0;
                            pixel_valid_d = 1'b1;
                            pixel_data_d  = {hi_q, byte_data_q[7:0]};
                            pixel_x_d     = x_q;
                            pixel_y_d     = y_q;
                            if (x_q >= xe_q) begin
                                x_d = xs_q;
                                y_d = (y_q >= ye_q) ? ys_q : y_q + 9'd1;
                            end else begin
                                x_d = x_q + 9'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // State registers for both the byte assembler and the decoder
    always_ff @(posedge sys_clk_50MHz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            bit_cnt_q     <= 3'd0;
            shift_q       <= 7'd0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= 9'd0;
            frame_err_q   <= 1'b0;
            state_q       <= ST_IDLE;
            param_cnt_q   <= 2'd0;
            sh_start_hi_q <= 1'b0;
            sh_start_lo_q <= 8'd0;
            sh_end_hi_q   <= 1'b0;
            xs_q          <= 9'd0;
            xe_q          <= XE_RST;
            ys_q          <= 9'd0;
            ye_q          <= YE_RST;
            x_q           <= 9'd0;
            y_q           <= 9'd0;
            phase_q       <= 1'b0;
            hi_q          <= 8'd0;
            cmd_valid_q   <= 1'b0;
            cmd_code_q    <= 8'd0;
            pixel_valid_q <= 1'b0;
            pixel_data_q  <= 16'd0;
            pixel_x_q     <= 9'd0;
            pixel_y_q     <= 9'd0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            param_cnt_q   <= param_cnt_d;
            sh_start_hi_q <= sh_start_hi_d;
            sh_start_lo_q <= sh_start_lo_d;
            sh_end_hi_q   <= sh_end_hi_d;
            xs_q          <= xs_d;
            xe_q          <= xe_d;
            ys_q          <= ys_d;
            ye_q          <= ye_d;
            x_q           <= x_d;
            y_q           <= y_d;
            phase_q       <= phase_d;
            hi_q          <= hi_d;
            cmd_valid_q   <= cmd_valid_d;
            cmd_code_q    <= cmd_code_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_data_q  <= pixel_data_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
        end
    end

    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_code    = cmd_code_q;
    assign pixel_valid = pixel_valid_q;
    assign pixel_data  = pixel_data_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: drives SPI frames into lcd_spi_rx, predicts bytes, commands,
// pixels and framing errors with a window/pixel-count model, and checks them
// in a monitor that runs independently of the stimulus.
`timescale 1ns/1ps
module tb_lcd_spi_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1;
    logic        spi_dc = 1'b0;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        byte_valid, cmd_valid, pixel_valid, frame_err;
    logic [8:0]  byte_data, pixel_x, pixel_y;
    logic [7:0]  cmd_code;
    logic [15:0] pixel_data;

    lcd_spi_rx #(.WIDTH(240), .HEIGHT(320)) dut (
        .sys_clk_50MHz(clk),
        .sys_rst_n(rst_n),
        .spi_cs(spi_cs),
        .spi_dc(spi_dc),
        .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi),
        .byte_valid(byte_valid),
        .byte_data(byte_data),
        .cmd_valid(cmd_valid),
        .cmd_code(cmd_code),
        .pixel_valid(pixel_valid),
        .pixel_data(pixel_data),
        .pixel_x(pixel_x),
        .pixel_y(pixel_y),
        .frame_err(frame_err)
    );

    // 50 MHz system clock
    always #10 clk = ~clk;

    int cyc = 0;
    // Free-running cycle count used for latency and spacing checks
    always @(posedge clk) cyc = cyc + 1;

    typedef struct packed {
        logic [15:0] d;
        logic [8:0]  x;
        logic [8:0]  y;
    } pix_t;
    typedef enum {M_NONE, M_COL, M_ROW, M_MEM} mode_t;

    logic [8:0] exp_b[$];
    logic [7:0] exp_c[$];
    pix_t       exp_p[$];
    int         exp_fe = 0;
    int         vectors = 0;
    int         miscompares = 0;

    int    m_xs, m_xe, m_ys, m_ye, m_npix;
    mode_t m_mode;
    int    m_prm[$];
    bit    m_have_hi;
    logic [7:0] m_hi;

    logic [8:0] tx_q[$];
    int  last_b = -100;
    bit  have_prev = 0;
    bit  chk_spacing = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic noteUnexpected(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: output pulse with nothing predicted (t=%0t)", name, $time);
    endtask

    function automatic void model_reset();
        m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319;
        m_mode = M_NONE;
        m_prm.delete();
        m_npix = 0;
        m_have_hi = 0;
    endfunction

    // Reference: window as integers, pixel position derived from the pixel index
    function automatic void model_byte(input logic [8:0] w);
        int s, e, wd, ht;
        pix_t p;
        exp_b.push_back(w);
        if (!w[8]) begin
            exp_c.push_back(w[7:0]);
            m_prm.delete();
            m_have_hi = 0;
            case (w[7:0])
                8'h2A: m_mode = M_COL;
                8'h2B: m_mode = M_ROW;
                8'h2C: begin m_mode = M_MEM; m_npix = 0; end
                8'h01: model_reset();
                default: m_mode = M_NONE;
            endcase
        end else if (m_mode == M_COL || m_mode == M_ROW) begin
            m_prm.push_back(int'(w[7:0]));
            if (m_prm.size() == 4) begin
                s = ((m_prm[0] << 8) | m_prm[1]) % 512;
                e = ((m_prm[2] << 8) | m_prm[3]) % 512;
                if (m_mode == M_COL) begin m_xs = s; m_xe = e; end
                else begin m_ys = s; m_ye = e; end
                m_mode = M_NONE;
                m_prm.delete();
            end
        end else if (m_mode == M_MEM) begin
            if (!m_have_hi) begin
                m_hi = w[7:0];
                m_have_hi = 1;
            end else begin
                wd = (m_xe >= m_xs) ? m_xe - m_xs + 1 : 1;
                ht = (m_ye >= m_ys) ? m_ye - m_ys + 1 : 1;
                p.d = {m_hi, w[7:0]};
                p.x = 9'(m_xs + m_npix % wd);
                p.y = 9'(m_ys + (m_npix / wd) % ht);
                exp_p.push_back(p);
                m_npix++;
                m_have_hi = 0;
            end
        end
    endfunction

    // Sends every word in tx_q inside one CS-low frame, SCLK = sys_clk/8
    task automatic applyStimulus();
        spi_cs = 1'b0;
        #100;
        foreach (tx_q[k]) begin
            model_byte(tx_q[k]);
            spi_dc = tx_q[k][8];
            for (int i = 7; i >= 0; i--) begin
                spi_mosi = tx_q[k][i];
                #80 spi_sclk = 1'b1;
                #80 spi_sclk = 1'b0;
            end
        end
        #100 spi_cs = 1'b1;
        m_have_hi = 0;
        tx_q.delete();
        #300;
    endtask

    task automatic sendPartial(input int nbits, input logic [7:0] b);
        spi_cs = 1'b0;
        #100;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = b[i];
            #80 spi_sclk = 1'b1;
            #80 spi_sclk = 1'b0;
        end
        #100 spi_cs = 1'b1;
        if (nbits != 0) exp_fe++;
        m_have_hi = 0;
        #300;
    endtask

    task automatic pushWin(input logic [7:0] cmd, input int s, input int e, input bit full);
        logic [15:0] sv, ev;
        sv = 16'(s) | (16'($urandom_range(0, 127)) << 9);
        ev = 16'(e) | (16'($urandom_range(0, 127)) << 9);
        tx_q.push_back({1'b0, cmd});
        tx_q.push_back({1'b1, sv[15:8]});
        tx_q.push_back({1'b1, sv[7:0]});
        if (full) begin
            tx_q.push_back({1'b1, ev[15:8]});
            tx_q.push_back({1'b1, ev[7:0]});
        end
    endtask

    task automatic pushPixels(input int n, input logic [15:0] base, input bit rnd);
        logic [15:0] v;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 16'($urandom) : base + 16'(i);
            tx_q.push_back({1'b1, v[15:8]});
            tx_q.push_back({1'b1, v[7:0]});
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an output
    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid) begin
                if (exp_c.size() == 0) noteUnexpected("cmd_valid");
                else checkOutput("cmd_code", 32'(cmd_code), 32'(exp_c.pop_front()));
                checkOutput("cmd_latency", 32'(cyc - last_b), 32'd1);
            end
            if (pixel_valid) begin
                if (exp_p.size() == 0) noteUnexpected("pixel_valid");
                else begin
                    pix_t p;
                    p = exp_p.pop_front();
                    checkOutput("pixel_data", 32'(pixel_data), 32'(p.d));
                    checkOutput("pixel_x", 32'(pixel_x), 32'(p.x));
                    checkOutput("pixel_y", 32'(pixel_y), 32'(p.y));
                end
                checkOutput("pixel_latency", 32'(cyc - last_b), 32'd1);
            end
            if (byte_valid) begin
                if (exp_b.size() == 0) noteUnexpected("byte_valid");
                else checkOutput("byte_data", 32'(byte_data), 32'(exp_b.pop_front()));
                if (chk_spacing && have_prev)
                    checkOutput("byte_spacing", 32'(cyc - last_b), 32'd64);
                last_b = cyc;
                have_prev = 1;
            end
            if (frame_err) begin
                checkOutput("frame_err_predicted", 32'(exp_fe > 0), 32'd1);
                if (exp_fe > 0) exp_fe--;
            end
        end
    end

    task automatic checkResetOutputs();
        checkOutput("rst_byte_valid", 32'(byte_valid), 32'd0);
        checkOutput("rst_byte_data", 32'(byte_data), 32'd0);
        checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        checkOutput("rst_cmd_code", 32'(cmd_code), 32'd0);
        checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        checkOutput("rst_pixel_data", 32'(pixel_data), 32'd0);
        checkOutput("rst_pixel_x", 32'(pixel_x), 32'd0);
        checkOutput("rst_pixel_y", 32'(pixel_y), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
    endtask

    // Watchdog so the run always ends
    initial begin
        #1800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        int xs, xe, ys, ye, n;
        model_reset();
        #55;
        checkResetOutputs();
        rst_n = 1'b1;
        #100;

        tx_q.push_back(9'h02A);
        applyStimulus();

        sendPartial(5, 8'hC3);
        tx_q.push_back(9'h1A5);
        applyStimulus();

        tx_q = '{9'h02A, 9'h100, 9'h110};
        applyStimulus();
        tx_q = '{9'h02C, 9'h112, 9'h134};
        applyStimulus();

        tx_q = '{9'h02A, 9'h100, 9'h110, 9'h100, 9'h11F};
        applyStimulus();
        tx_q = '{9'h02B, 9'h100, 9'h120, 9'h100, 9'h121};
        applyStimulus();
        tx_q.push_back(9'h02C);
        pushPixels(33, 16'h1234, 0);
        applyStimulus();

        tx_q.push_back(9'h001);
        applyStimulus();
        tx_q.push_back(9'h02C);
        pushPixels(2, 16'hBEEF, 0);
        applyStimulus();

        rst_n = 1'b0;
        #50;
        checkResetOutputs();
        model_reset();
        rst_n = 1'b1;
        #100;
        tx_q = '{9'h1AA, 9'h155, 9'h1AA, 9'h155};
        applyStimulus();
        tx_q = '{9'h02C, 9'h1AB, 9'h1CD};
        applyStimulus();

        tx_q.push_back(9'h000);
        for (int i = 0; i < 6; i++) tx_q.push_back({1'b1, 8'($urandom)});
        have_prev = 0;
        chk_spacing = 1;
        applyStimulus();
        chk_spacing = 0;

        for (int it = 0; it < 12; it++) begin
            xs = $urandom_range(0, 300);
            xe = ($urandom_range(0, 5) == 0) ? xs - 1 : xs + $urandom_range(0, 4);
            ys = $urandom_range(0, 300);
            ye = ($urandom_range(0, 5) == 0) ? ys - 1 : ys + $urandom_range(0, 2);
            if (xe < 0) xe = 0;
            if (ye < 0) ye = 0;
            pushWin(8'h2A, xs, xe, $urandom_range(0, 4) != 0);
            applyStimulus();
            pushWin(8'h2B, ys, ye, $urandom_range(0, 4) != 0);
            applyStimulus();
            n = $urandom_range(1, 10);
            tx_q.push_back(9'h02C);
            pushPixels(n, 16'h0, 1);
            if ($urandom_range(0, 2) == 0) tx_q.push_back({1'b1, 8'($urandom)});
            applyStimulus();
            pushPixels($urandom_range(0, 3), 16'h0, 1);
            if (tx_q.size() > 0) applyStimulus();
            if ($urandom_range(0, 3) == 0) sendPartial($urandom_range(1, 7), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tx_q.push_back({1'b0, 8'($urandom)});
                tx_q.push_back({1'b1, 8'($urandom)});
                tx_q.push_back({1'b1, 8'($urandom)});
                applyStimulus();
            end
        end

        #1000;
        checkOutput("byte_queue_drained", 32'(exp_b.size()), 32'd0);
        checkOutput("cmd_queue_drained", 32'(exp_c.size()), 32'd0);
        checkOutput("pixel_queue_drained", 32'(exp_p.size()), 32'd0);
        checkOutput("frame_err_drained", 32'(exp_fe), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
